// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter: N:1 round-robin stream arbiter with optional burst lock.
// Selection is combinational from a rotating priority pointer. Once a beat
// is offered but stalled, or a multi-beat burst has started, the grant is
// pinned to that requester until the grant ends.

// Per-requester slice: gates ready/valid/last/data by the one-hot grant hit.
module axi_rr_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  hit,
  input  logic                  valid,
  input  logic                  last,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  out_ready,
  output logic                  ready,
  output logic                  valid_m,
  output logic                  last_m,
  output logic [DATA_WIDTH-1:0] data_m
);
  assign ready   = out_ready & hit;
  assign valid_m = valid & hit;
  assign last_m  = last & hit;
  assign data_m  = data & {DATA_WIDTH{hit}};
endmodule

module axi_rr_arbiter #(
  parameter  int N_REQ      = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int BURST_LOCK = 1,
  localparam int IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [N_REQ-1:0]            req_last_i,
  output logic [N_REQ-1:0]            req_ready_o,
  output logic                        out_valid_o,
  output logic [DATA_WIDTH-1:0]       out_data_o,
  output logic                        out_last_o,
  output logic [IDX_W-1:0]            out_id_o,
  input  logic                        out_ready_i
);
  // Candidate index carries one extra bit so rr_q + offset never overflows
  // before the wrap correction.
  localparam int CW = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, HOLD, BURST} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] sel, rr_inc;
  logic [CW-1:0]    cand;
  logic             found;
  logic             hs, grant_end;

  logic [N_REQ-1:0]                 hit, valid_m, last_m;
  logic [N_REQ-1:0][DATA_WIDTH-1:0] data_in, data_m;

  assign data_in = req_data_i;

  // Selection: locked grant in HOLD/BURST, else first valid from rr_q with wrap.
  always_comb begin
    sel   = rr_q;
    found = 1'b0;
    cand  = '0;
    if (state_q != IDLE) begin
      sel = gnt_q;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = {1'b0, rr_q} + CW'(k);
        if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
        if (!found && req_valid_i[cand[IDX_W-1:0]]) begin
          sel   = cand[IDX_W-1:0];
          found = 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign hit[i] = (sel == IDX_W'(i));
    axi_rr_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .hit       (hit[i]),
      .valid     (req_valid_i[i]),
      .last      (req_last_i[i]),
      .data      (data_in[i]),
      .out_ready (out_ready_i),
      .ready     (req_ready_o[i]),
      .valid_m   (valid_m[i]),
      .last_m    (last_m[i]),
      .data_m    (data_m[i])
    );
  end

  assign out_valid_o = |valid_m;
  assign out_last_o  = |last_m;
  assign out_id_o    = sel;

  // AND-OR mux: only the hit lane contributes non-zero data.
  always_comb begin
    out_data_o = '0;
    for (int i = 0; i < N_REQ; i++) out_data_o = out_data_o | data_m[i];
  end

  assign hs        = out_valid_o & out_ready_i;
  assign grant_end = out_last_o | (BURST_LOCK == 0);
  assign rr_inc    = (sel == IDX_W'(N_REQ - 1)) ? '0 : sel + IDX_W'(1);

  // Next state: lock on stall or burst start, release and rotate on grant end.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE, HOLD: begin
        if (hs) begin
          if (grant_end) begin
            state_d = IDLE;
            rr_d    = rr_inc;
          end else begin
            state_d = BURST;
            gnt_d   = sel;
          end
        end else if (state_q == IDLE && out_valid_o) begin
          state_d = HOLD;
          gnt_d   = sel;
        end
      end
      BURST: begin
        if (hs && grant_end) begin
          state_d = IDLE;
          rr_d    = rr_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any lock and restarts priority at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
    end
  end
endmodule
